// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: decodes branch/writeback info from the ALU result at capture and
// holds it in a 2-entry (main + skid) buffer so in_ready never depends on out_ready combinationally.
module alu_result_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_zero,
    input  logic               alu_negative,
    input  logic               op_a_sign,
    input  logic               op_b_sign,
    input  logic [2:0]         branch_op,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    imm,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    wb_data,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_en,
    output logic               branch_taken,
    output logic [XLEN-1:0]    branch_target
);

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_JAL  = 3'd5;
    localparam logic [2:0] BR_JALR = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]    data;
        logic [RADDR_W-1:0] rd;
        logic               en;
        logic               taken;
        logic [XLEN-1:0]    target;
    } entry_t;

    entry_t dec, main_q, skid_q, out_e;
    logic   main_valid, skid_valid;
    logic   ovf, lt, accept, retire;

    // Signed less-than recovered from the subtraction flags
    always_comb begin
        ovf = (op_a_sign != op_b_sign) & (alu_negative != op_a_sign);
        lt  = alu_negative ^ ovf;
        dec = '0;
        dec.rd   = rd;
        dec.en   = reg_write & (rd != '0);
        dec.data = alu_out;
        case (branch_op)
            BR_BEQ:  dec.taken = alu_zero;
            BR_BNE:  dec.taken = ~alu_zero;
            BR_BLT:  dec.taken = lt;
            BR_BGE:  dec.taken = ~lt;
            BR_JAL:  dec.taken = 1'b1;
            BR_JALR: dec.taken = 1'b1;
            default: dec.taken = 1'b0;
        endcase
        if (branch_op == BR_JAL || branch_op == BR_JALR)
            dec.data = pc + XLEN'(4);
        if (dec.taken)
            dec.target = (branch_op == BR_JALR) ? (alu_out & ~XLEN'(1)) : (pc + imm);
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign retire   = main_valid & out_ready;

    // Skid is only ever occupied while main is occupied, so main always holds the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || retire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept)
                    main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_e         = main_valid ? main_q : '0;
    assign out_valid     = main_valid;
    assign wb_data       = out_e.data;
    assign wb_rd         = out_e.rd;
    assign wb_en         = out_e.en;
    assign branch_taken  = out_e.taken;
    assign branch_target = out_e.target;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage: expected entries come from a signed-compare model of
// the operands and flow through a FIFO queue mirroring the stage's handshake-level behaviour.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] alu_out, pc, imm, wb_data, branch_target;
    logic        alu_zero, alu_negative, op_a_sign, op_b_sign, reg_write, wb_en, branch_taken;
    logic [2:0]  branch_op;
    logic [4:0]  rd, wb_rd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] alu_out;
        logic        zero, neg, as, bs;
        logic [2:0]  op;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic        rw;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en, taken;
        logic [31:0] target;
    } exp_t;

    exp_t  q[$];
    stim_t s_idle;
    exp_t  e_idle;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .op_a_sign(op_a_sign), .op_b_sign(op_b_sign), .branch_op(branch_op),
        .pc(pc), .imm(imm), .rd(rd), .reg_write(reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_en(wb_en), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ordy, input stim_t s);
        in_valid     = v;
        out_ready    = ordy;
        alu_out      = s.alu_out;
        alu_zero     = s.zero;
        alu_negative = s.neg;
        op_a_sign    = s.as;
        op_b_sign    = s.bs;
        branch_op    = s.op;
        pc           = s.pc;
        imm          = s.imm;
        rd           = s.rd;
        reg_write    = s.rw;
    endtask

    // One cycle: check outputs against the model queue, drive new inputs, advance the model
    task automatic step(input logic v, input logic ordy, input stim_t s, input exp_t e);
        int   n;
        exp_t tmp;
        @(negedge clk);
        n = q.size();
        check("out_valid", out_valid, n > 0);
        check("in_ready", in_ready, n < 2);
        if (n > 0) begin
            check("wb_data", wb_data, q[0].data);
            check("wb_rd", wb_rd, q[0].rd);
            check("wb_en", wb_en, q[0].en);
            check("branch_taken", branch_taken, q[0].taken);
            check("branch_target", branch_target, q[0].target);
        end else begin
            check("idle_zero", {wb_data, wb_rd, wb_en, branch_taken, branch_target}, '0);
        end
        drive(v, ordy, s);
        if (ordy && n > 0) tmp = q.pop_front();
        if (v && n < 2) q.push_back(e);
    endtask

    // Operands a,b go through a subtracting ALU; branch outcome judged by direct signed compare
    task automatic gen(output stim_t s, output exp_t e);
        logic [31:0] a, b, res;
        a = $urandom;
        b = ($urandom_range(3) == 0) ? a : $urandom;
        if ($urandom_range(3) == 0) b = {~a[31], b[30:0]};
        res = a - b;
        s.alu_out = res;
        s.zero = (res == 0);
        s.neg = res[31];
        s.as = a[31];
        s.bs = b[31];
        s.op = 3'($urandom_range(7));
        s.pc = $urandom;
        s.imm = $urandom;
        s.rd = 5'($urandom_range(31));
        s.rw = 1'($urandom_range(1));
        case (s.op)
            3'd1: e.taken = (a == b);
            3'd2: e.taken = (a != b);
            3'd3: e.taken = ($signed(a) < $signed(b));
            3'd4: e.taken = ($signed(a) >= $signed(b));
            3'd5, 3'd6: e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.target = !e.taken ? 32'd0 : (s.op == 3'd6) ? {res[31:1], 1'b0} : s.pc + s.imm;
        e.data   = (s.op == 3'd5 || s.op == 3'd6) ? s.pc + 32'd4 : res;
        e.rd     = s.rd;
        e.en     = s.rw && s.rd != 0;
    endtask

    function automatic stim_t mk(input logic [31:0] ao, input logic z, neg, as, bs,
                                 input logic [2:0] op, input logic [31:0] p, im,
                                 input logic [4:0] r, input logic rw);
        stim_t s;
        s.alu_out = ao; s.zero = z; s.neg = neg; s.as = as; s.bs = bs;
        s.op = op; s.pc = p; s.imm = im; s.rd = r; s.rw = rw;
        return s;
    endfunction

    function automatic exp_t mke(input logic [31:0] d, input logic [4:0] r, input logic en, tk,
                                 input logic [31:0] tg);
        exp_t e;
        e.data = d; e.rd = r; e.en = en; e.taken = tk; e.target = tg;
        return e;
    endfunction

    initial begin
        stim_t s, sc;
        exp_t  e, ec;
        s_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_idle = mke(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, s_idle);
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {wb_data, wb_rd, wb_en, branch_taken, branch_target}, '0);
        rst_n = 1'b1;

        // Directed decode corner cases
        step(1, 1, mk(32'h8000_0001, 0, 1, 0, 1, 3'd3, 32'h100, 32'h20, 5'd3, 0),
             mke(32'h8000_0001, 5'd3, 0, 0, 0));
        step(1, 1, mk(32'h8000_0001, 0, 1, 1, 1, 3'd3, 32'h100, 32'h20, 5'd3, 0),
             mke(32'h8000_0001, 5'd3, 0, 1, 32'h120));
        step(1, 1, mk(32'h0000_2003, 0, 0, 0, 0, 3'd6, 32'hFFFF_FFFC, 32'h0, 5'd1, 1),
             mke(32'h0, 5'd1, 1, 1, 32'h2002));
        step(1, 1, mk(32'd5, 0, 0, 0, 0, 3'd0, 32'h40, 32'h8, 5'd0, 1),
             mke(32'd5, 5'd0, 0, 0, 0));
        step(0, 1, s_idle, e_idle);

        // Backpressure: A,B held, C stalls until the skid drains
        gen(s, e); step(1, 0, s, e);
        gen(s, e); step(1, 0, s, e);
        gen(sc, ec);
        repeat (2) step(1, 0, sc, ec);
        repeat (2) step(1, 1, sc, ec);
        repeat (3) step(0, 1, s_idle, e_idle);

        // Full throughput
        for (int i = 0; i < 16; i++) begin
            gen(s, e);
            step(1, 1, s, e);
        end
        repeat (2) step(0, 1, s_idle, e_idle);

        // Random handshakes
        for (int i = 0; i < 400; i++) begin
            gen(s, e);
            step(1'($urandom_range(1)), ($urandom_range(3) != 0), s, e);
        end
        repeat (3) step(0, 1, s_idle, e_idle);

        // Async reset with both entries occupied
        gen(s, e); step(1, 0, s, e);
        gen(s, e); step(1, 0, s, e);
        step(0, 0, s_idle, e_idle);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_outputs", {wb_data, wb_rd, wb_en, branch_taken, branch_target}, '0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_mid_in_ready", in_ready, 1);
        gen(s, e); step(1, 1, s, e);
        repeat (2) step(0, 1, s_idle, e_idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
